mem_access_stage: RTL

- MEM pipeline stage, directly downstream of the EX/MEM pipeline register; consumes its write-back fields, ALU op and memory address.
- Non-memory ops pass through to the MEM/WB register in the same cycle.
- Loads and stores run a multi-cycle req/ack transaction on the data-memory bus.
- Asserts stall_req to the pipeline controller until the access completes, which freezes EX/MEM and everything upstream.

---
 rtl/mem_access_stage_pkg.sv | 38 +++
 rtl/mem_access_stage_lane.sv | 67 ++++++
 rtl/mem_access_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared op codes, bus widths and FSM encodings for the MEM stage.
// Op encoding must match the EX stage's ALU op table.
package mem_access_stage_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 6;

  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0;

  localparam logic [5:0] EX_NOP_OP = 6'h00;
  localparam logic [5:0] EX_ADD_OP = 6'h01;
  localparam logic [5:0] EX_LB_OP  = 6'h20;
  localparam logic [5:0] EX_LH_OP  = 6'h21;
  localparam logic [5:0] EX_LW_OP  = 6'h22;
  localparam logic [5:0] EX_LBU_OP = 6'h23;
  localparam logic [5:0] EX_LHU_OP = 6'h24;
  localparam logic [5:0] EX_SB_OP  = 6'h25;
  localparam logic [5:0] EX_SH_OP  = 6'h26;
  localparam logic [5:0] EX_SW_OP  = 6'h27;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic is_load_op(logic [5:0] op);
    return (op == EX_LB_OP)  || (op == EX_LH_OP) ||
           (op == EX_LW_OP)  || (op == EX_LBU_OP) ||
           (op == EX_LHU_OP);
  endfunction

  function automatic logic is_store_op(logic [5:0] op);
    return (op == EX_SB_OP) || (op == EX_SH_OP) ||
           (op == EX_SW_OP);
  endfunction

endpackage

// File: rtl/mem_access_stage_lane.sv
// Byte-lane steering: store strobes/data and load extract/extend.
// Misalignment flag is only raised when CHECK_EN is set.
module mem_lane_align
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALUOP_W  = 6,
  parameter bit CHECK_EN = 1'b0
) (
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [XLEN-1:0]    sdata_i,
  input  logic [XLEN-1:0]    rdata_i,
  output logic [3:0]         wstrb_o,
  output logic [XLEN-1:0]    wdata_o,
  output logic [XLEN-1:0]    ldata_o,
  output logic               misalign_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        mis_raw;

  assign byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  // Decode op into lane strobes, store data, load data.
  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = sdata_i;
    ldata_o = rdata_i;
    mis_raw = 1'b0;
    unique case (1'b1)
      aluop_i == EX_LB_OP:
        ldata_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      aluop_i == EX_LBU_OP:
        ldata_o = {{(XLEN-8){1'b0}}, byte_v};
      aluop_i == EX_LH_OP: begin
        ldata_o = {{(XLEN-16){half_v[15]}}, half_v};
        mis_raw = addr_lo_i[0];
      end
      aluop_i == EX_LHU_OP: begin
        ldata_o = {{(XLEN-16){1'b0}}, half_v};
        mis_raw = addr_lo_i[0];
      end
      aluop_i == EX_LW_OP:
        mis_raw = |addr_lo_i;
      aluop_i == EX_SB_OP: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {(XLEN/8){sdata_i[7:0]}};
      end
      aluop_i == EX_SH_OP: begin
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {(XLEN/16){sdata_i[15:0]}};
        mis_raw = addr_lo_i[0];
      end
      aluop_i == EX_SW_OP: begin
        wstrb_o = 4'b1111;
        mis_raw = |addr_lo_i;
      end
      default: ;
    endcase
  end

  assign misalign_o = CHECK_EN & mis_raw;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: pass-through for ALU ops, req/ack bus FSM for loads/stores.
// Optional MEM_MISALIGN_CHECK_EN: trap misaligned accesses instead of aligning.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN    = RegBus,
  parameter int REG_AW  = RegAddrBus,
  parameter int ALUOP_W = AluOpBus
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               me_w_enable,
  input  logic [REG_AW-1:0]  me_w_addr,
  input  logic [XLEN-1:0]    me_w_data,
  input  logic [ALUOP_W-1:0] me_aluop,
  input  logic [XLEN-1:0]    me_mem_addr,
  output logic               wb_w_enable,
  output logic [REG_AW-1:0]  wb_w_addr,
  output logic [XLEN-1:0]    wb_w_data,
  output logic               stall_req,
  output logic               mem_req,
  output logic               mem_we,
  output logic [XLEN-1:0]    mem_addr,
  output logic [3:0]         mem_wstrb,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic [XLEN-1:0]    mem_rdata,
  input  logic               mem_ack,
  output logic               misalign_exc
);

`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MisChk = 1'b1;
`else
  localparam bit MisChk = 1'b0;
`endif

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] rdata_q;
  logic            is_ld, is_st, is_mem;
  logic [3:0]      ln_wstrb;
  logic [XLEN-1:0] ln_wdata, ln_ldata;
  logic            ln_mis, issue;

  assign is_ld  = is_load_op(me_aluop);
  assign is_st  = is_store_op(me_aluop);
  assign is_mem = is_ld | is_st;

  mem_lane_align #(
    .XLEN    (XLEN),
    .ALUOP_W (ALUOP_W),
    .CHECK_EN(MisChk)
  ) u_lane (
    .aluop_i   (me_aluop),
    .addr_lo_i (me_mem_addr[1:0]),
    .sdata_i   (me_w_data),
    .rdata_i   (rdata_q),
    .wstrb_o   (ln_wstrb),
    .wdata_o   (ln_wdata),
    .ldata_o   (ln_ldata),
    .misalign_o(ln_mis)
  );

  assign issue = (state_q == S_IDLE) & is_mem & ~ln_mis;

  // Next state and write-back / stall outputs.
  always_comb begin
    state_d      = state_q;
    wb_w_enable  = me_w_enable;
    wb_w_addr    = me_w_addr;
    wb_w_data    = me_w_data;
    stall_req    = 1'b0;
    misalign_exc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          wb_w_enable = WriteDisable;
          if (ln_mis) begin
            misalign_exc = 1'b1;
          end else begin
            stall_req = 1'b1;
            state_d   = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall_req   = 1'b1;
        wb_w_enable = WriteDisable;
        if (mem_ack) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (is_ld) wb_w_data = ln_ldata;
        else       wb_w_enable = WriteDisable;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Bus request launch/hold/release and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
      rdata_q   <= '0;
    end else if (issue) begin
      mem_req   <= 1'b1;
      mem_we    <= is_st;
      mem_addr  <= {me_mem_addr[XLEN-1:2], 2'b00};
      mem_wstrb <= ln_wstrb;
      mem_wdata <= ln_wdata;
    end else if ((state_q == S_BUSY) && mem_ack) begin
      mem_req <= 1'b0;
      rdata_q <= mem_rdata;
    end
  end

endmodule
